// File: rtl/cam_pattern_tx.sv
// Synthetic OV7670-style DVP camera: emits PCLK/VSYNC/HREF and RGB444 bytes from built-in patterns.
// Latency: PCLK is free-running at clk/2; VSYNC rises on the first PCLK falling edge after enable.
// Backpressure: none -- a free-running source; frames always run to completion once started.
//
// Ports:
//   clk, rst (async, active-low)        sole clock and reset
//   enable                              stream frames continuously while high
//   pattern_sel[1:0], solid_color[11:0] pattern controls, latched at each frame start
//   CAM_pclk, CAM_vsync, CAM_href       DVP timing outputs
//   CAM_px_data[7:0]                    pixel byte, 0 outside HREF
//   frame_done, frame_cnt[15:0]         end-of-frame pulse and completed-frame counter
module cam_pattern_tx #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int VS_LEN = 8,
    parameter int VBP    = 16,
    parameter int HBLANK = 16,
    parameter int VFP    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_color,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int M1    = (VS_LEN > VBP) ? VS_LEN : VBP;
    localparam int M2    = (HBLANK > VFP) ? HBLANK : VFP;
    localparam int CMAX  = (M1 > M2) ? M1 : M2;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int BAR_W = (IMG_W / 8 > 0) ? IMG_W / 8 : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            phase_q, phase_d;   // 0 = high nibble byte, 1 = low byte
    logic [1:0]      pat_q;
    logic [11:0]     solid_q;
    logic            latch;
    logic            done;
    logic            tick;

    // A tick is the clk edge on which PCLK falls; all timing state moves only then,
    // so every output is stable across the following PCLK rising edge.
    assign tick = CAM_pclk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            CAM_pclk   <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            phase_q    <= 1'b0;
            pat_q      <= 2'd0;
            solid_q    <= 12'h000;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            CAM_pclk   <= ~CAM_pclk;
            frame_done <= 1'b0;
            if (tick) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                x_q     <= x_d;
                y_q     <= y_d;
                phase_q <= phase_d;
                if (latch) begin
                    pat_q   <= pattern_sel;
                    solid_q <= solid_color;
                end
                if (done) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
            end
        end
    end

    // Next-state logic, evaluated as if the current edge were a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;
        latch   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_VSYNC;
                    cnt_d   = '0;
                    latch   = 1'b1;
                end
            end
            S_VSYNC: begin
                if (cnt_q == CW'(VS_LEN - 1)) begin
                    state_d = S_VBP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VBP: begin
                if (cnt_q == CW'(VBP - 1)) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LINE: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (x_q == XW'(IMG_W - 1)) begin
                        state_d = S_HBLANK;
                        cnt_d   = '0;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == CW'(HBLANK - 1)) begin
                    cnt_d = '0;
                    if (y_q == YW'(IMG_H - 1)) begin
                        state_d = S_VFP;
                    end else begin
                        state_d = S_LINE;
                        y_d     = y_q + 1'b1;
                        x_d     = '0;
                        phase_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_VFP: begin
                if (cnt_q == CW'(VFP - 1)) begin
                    done  = 1'b1;
                    cnt_d = '0;
                    if (enable) begin
                        state_d = S_VSYNC;
                        latch   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel generation from the current (x,y) and the per-frame latched pattern.
    logic [11:0]   pix;
    logic [XW-1:0] bar_idx;
    logic [2:0]    bar;

    always_comb begin
        bar_idx = x_q / XW'(BAR_W);
        // Pixels past the eighth bar (IMG_W not divisible by 8) stay on the last bar.
        bar     = (bar_idx > XW'(7)) ? 3'd7 : bar_idx[2:0];
        pix     = 12'h000;
        case (pat_q)
            2'd0: pix = solid_q;
            2'd1: begin
                case (bar)
                    3'd0:    pix = 12'hFFF;
                    3'd1:    pix = 12'hFF0;
                    3'd2:    pix = 12'h0FF;
                    3'd3:    pix = 12'h0F0;
                    3'd4:    pix = 12'hF0F;
                    3'd5:    pix = 12'hF00;
                    3'd6:    pix = 12'h00F;
                    default: pix = 12'h000;
                endcase
            end
            2'd2: pix = 12'(32'(x_q) + 32'(y_q) * 32'(IMG_W));
            default: pix = (x_q[3] ^ y_q[3]) ? 12'hFFF : 12'h000;
        endcase
    end

    assign CAM_vsync   = (state_q == S_VSYNC);
    assign CAM_href    = (state_q == S_LINE);
    assign CAM_px_data = (state_q != S_LINE) ? 8'h00 :
                         (phase_q ? pix[7:0] : {4'h0, pix[11:8]});

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Scoreboarded bench for cam_pattern_tx with a reduced frame height.
// Latency: expectations are queued ahead of each frame; the monitor consumes one byte per PCLK high.
// Backpressure: not applicable; the DUT free-runs.
module tb_cam_pattern_tx;

    localparam int W   = 160;
    localparam int H   = 10;
    localparam int VS  = 8;
    localparam int VB  = 16;
    localparam int HB  = 16;
    localparam int VF  = 16;
    localparam int FRAME_CLK = 2 * (VS + VB + H * (2 * W + HB) + VF);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [11:0] solid_color = 12'h000;
    logic        CAM_pclk, CAM_vsync, CAM_href, frame_done;
    logic [7:0]  CAM_px_data;
    logic [15:0] frame_cnt;

    cam_pattern_tx #(
        .IMG_W(W), .IMG_H(H), .VS_LEN(VS), .VBP(VB), .HBLANK(HB), .VFP(VF)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pattern_sel(pattern_sel), .solid_color(solid_color),
        .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
        .CAM_px_data(CAM_px_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit sb_active = 1'b1;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pixel model written directly from the pattern definitions.
    function automatic logic [11:0] ref_pix(input int pat, input logic [11:0] solid,
                                            input int x, input int y);
        logic [11:0] bars [8];
        int b;
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        case (pat)
            0: return solid;
            1: begin
                b = x / (W / 8);
                if (b > 7) b = 7;
                return bars[b];
            end
            2: return 12'((y * W + x) % 4096);
            default: return ((((x / 8) % 2) != ((y / 8) % 2))) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    task automatic push_frame(input int pat, input logic [11:0] solid);
        logic [11:0] p;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                p = ref_pix(pat, solid, x, y);
                exp_q.push_back({4'h0, p[11:8]});
                exp_q.push_back(p[7:0]);
            end
        end
    endtask

    // Monitor: one byte per PCLK-high half; idle bytes must be zero.
    always @(negedge clk) begin
        if (rst && CAM_pclk && sb_active) begin
            if (CAM_href) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, CAM_px_data}, 32'hFFFF_FFFF);
                end else begin
                    check("px_byte", {24'h0, CAM_px_data}, {24'h0, exp_q.pop_front()});
                end
            end else begin
                check("px_zero_outside_href", {24'h0, CAM_px_data}, 32'h0);
            end
        end
    end

    task automatic wait_href_rise(input string name);
        int n = 0;
        while (CAM_href !== 1'b0 && n < 4 * FRAME_CLK) begin @(negedge clk); n++; end
        while (CAM_href !== 1'b1 && n < 4 * FRAME_CLK) begin @(negedge clk); n++; end
        if (n >= 4 * FRAME_CLK) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < 2 * FRAME_CLK) begin @(negedge clk); n++; end
        if (n >= 2 * FRAME_CLK) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n, pulses, start_cyc, since_rise;
        logic prev;

        // Reset held with enable high: everything quiet.
        enable      = 1'b1;
        pattern_sel = 2'd0;
        solid_color = 12'hA5C;
        repeat (4) @(negedge clk);
        check("rst_pclk",       {31'h0, CAM_pclk},    32'd0);
        check("rst_vsync",      {31'h0, CAM_vsync},   32'd0);
        check("rst_href",       {31'h0, CAM_href},    32'd0);
        check("rst_data",       {24'h0, CAM_px_data}, 32'd0);
        check("rst_frame_done", {31'h0, frame_done},  32'd0);
        check("rst_frame_cnt",  {16'h0, frame_cnt},   32'd0);

        // Frame 0: solid A5C, with timing measurements.
        push_frame(0, 12'hA5C);
        rst = 1'b1;
        @(negedge clk);
        check("pclk_first_high", {31'h0, CAM_pclk},  32'd1);
        check("vsync_pre_tick",  {31'h0, CAM_vsync}, 32'd0);
        @(negedge clk);
        check("pclk_first_tick", {31'h0, CAM_pclk},  32'd0);
        check("vsync_first_tick", {31'h0, CAM_vsync}, 32'd1);
        start_cyc = cyc;
        n = 0;
        while (CAM_vsync === 1'b1 && n < 1000) begin n++; @(negedge clk); end
        check("vsync_width_clk", n, 32'd16);

        // Next frame's pattern, latched at the end of this frame.
        pattern_sel = 2'd1;
        push_frame(1, 12'h000);

        wait_href_rise("href0");
        n = 0;
        while (CAM_href === 1'b1 && n < 4000) begin n++; @(negedge clk); end
        check("href_width_clk", n, 32'd640);
        pulses = 1;
        prev = CAM_href;
        n = 0;
        while (frame_done !== 1'b1 && n < 2 * FRAME_CLK) begin
            @(negedge clk);
            n++;
            if (CAM_href && !prev) pulses++;
            prev = CAM_href;
        end
        check("href_pulses_f0", pulses, H);
        check("frame_done_time", cyc - start_cyc, FRAME_CLK);
        check("frame_cnt_1", {16'h0, frame_cnt}, 32'd1);
        @(negedge clk);
        check("frame_done_1clk", {31'h0, frame_done}, 32'd0);

        // Frame 1 (colour bars) running; queue ramp for frame 2.
        wait_href_rise("href1");
        pattern_sel = 2'd2;
        push_frame(2, 12'h000);
        wait_done("done1");
        check("frame_cnt_2", {16'h0, frame_cnt}, 32'd2);

        // Frame 2 (ramp) running; queue checker for frame 3.
        wait_href_rise("href2");
        pattern_sel = 2'd3;
        push_frame(3, 12'h000);
        wait_done("done2");
        check("frame_cnt_3", {16'h0, frame_cnt}, 32'd3);

        // Frame 3: drop enable in the middle of a line; frame must still complete.
        pulses = 0;
        prev = CAM_href;
        since_rise = 0;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 2 * FRAME_CLK) begin
            if (CAM_href && !prev) begin pulses++; since_rise = 0; end
            else since_rise++;
            if (pulses == H / 2 && since_rise == 100) enable = 1'b0;
            prev = CAM_href;
            @(negedge clk);
            n++;
        end
        check("enable_dropped", {31'h0, enable}, 32'd0);
        check("href_pulses_f3", pulses, H);
        check("frame_cnt_4", {16'h0, frame_cnt}, 32'd4);
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (CAM_vsync || CAM_href) n++;
        end
        check("idle_no_sync", n, 32'd0);
        check("frame_cnt_idle", {16'h0, frame_cnt}, 32'd4);
        check("queue_drained", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a line.
        sb_active   = 1'b0;
        pattern_sel = 2'd0;
        solid_color = 12'h123;
        enable      = 1'b1;
        wait_href_rise("href_rst");
        repeat (20) @(negedge clk);
        check("pre_rst_href", {31'h0, CAM_href}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_pclk",      {31'h0, CAM_pclk},    32'd0);
        check("arst_vsync",     {31'h0, CAM_vsync},   32'd0);
        check("arst_href",      {31'h0, CAM_href},    32'd0);
        check("arst_data",      {24'h0, CAM_px_data}, 32'd0);
        check("arst_frame_cnt", {16'h0, frame_cnt},   32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
